// File: rtl/uart_frame_scheduler_if.sv
// Byte-stream handshake between the frame scheduler and the UART transmitter.
// The scheduler is the master: it offers tx_data/tx_valid and the transmitter
// answers with tx_ready.
interface uart_frame_scheduler_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_frame_scheduler.sv
// Outbound UART frame scheduler for the game link.
// Every TICK_DIV enabled frame ticks it snapshots the game state and streams a
// 10-byte frame (header, 8 payload bytes, XOR checksum) over a valid/ready
// byte interface. One further send request can queue up behind a running frame.
module uart_frame_scheduler #(
    parameter logic [7:0]  HEADER   = 8'hA5,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   frame_tick,
    input  logic [11:0]            pl1_posx,
    input  logic [11:0]            pl1_posy,
    input  logic [11:0]            ball_xpos,
    input  logic [11:0]            ball_ypos,
    input  logic [3:0]             score_pl1,
    input  logic [3:0]             score_pl2,
    input  logic                   endgame,
    input  logic                   whistle_play,
    input  logic                   last_touch,
    uart_frame_scheduler_if.master tx,
    output logic                   busy,
    output logic [7:0]             frames_sent
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);
    localparam logic [3:0] LAST_IDX  = 4'd9;

    logic [0:0]  state;
    logic [3:0]  byte_idx;
    logic [7:0]  tick_cnt;
    logic        pending;
    logic        whistle_latch;

    logic [11:0] snap_pl1_posx;
    logic [11:0] snap_pl1_posy;
    logic [11:0] snap_ball_xpos;
    logic [11:0] snap_ball_ypos;
    logic [3:0]  snap_score_pl1;
    logic [3:0]  snap_score_pl2;
    logic        snap_endgame;
    logic        snap_whistle;
    logic        snap_last_touch;

    logic        send_event;
    logic        handshake;
    logic        last_byte;
    logic        chain_frame;
    logic        take_snapshot;
    logic [7:0]  frame_byte;
    logic [7:0]  b1, b2, b3, b4, b5, b6, b7, b8, checksum;

    assign send_event    = enable && frame_tick && (tick_cnt == TICK_LAST);
    assign handshake     = (state == ST_SEND) && tx.tx_ready;
    assign last_byte     = (byte_idx == LAST_IDX);
    assign chain_frame   = handshake && last_byte && (pending || send_event);
    assign take_snapshot = ((state == ST_IDLE) && send_event) || chain_frame;

    assign tx.tx_valid = (state == ST_SEND);
    assign tx.tx_data  = (state == ST_SEND) ? frame_byte : 8'h00;
    assign busy        = (state == ST_SEND);

    // Count enabled ticks and wrap after TICK_DIV of them; frozen while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (enable && frame_tick) begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? 8'd0 : tick_cnt + 8'd1;
        end
    end

    // Hold a whistle request until a snapshot consumes it; a coincident pulse carries over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            whistle_latch <= 1'b0;
        end else if (take_snapshot) begin
            whistle_latch <= whistle_play;
        end else if (whistle_play) begin
            whistle_latch <= 1'b1;
        end
    end

    // Freeze the game state at frame start so the whole frame and its checksum agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_pl1_posx   <= '0;
            snap_pl1_posy   <= '0;
            snap_ball_xpos  <= '0;
            snap_ball_ypos  <= '0;
            snap_score_pl1  <= '0;
            snap_score_pl2  <= '0;
            snap_endgame    <= 1'b0;
            snap_whistle    <= 1'b0;
            snap_last_touch <= 1'b0;
        end else if (take_snapshot) begin
            snap_pl1_posx   <= pl1_posx;
            snap_pl1_posy   <= pl1_posy;
            snap_ball_xpos  <= ball_xpos;
            snap_ball_ypos  <= ball_ypos;
            snap_score_pl1  <= score_pl1;
            snap_score_pl2  <= score_pl2;
            snap_endgame    <= endgame;
            snap_whistle    <= whistle_latch;
            snap_last_touch <= last_touch;
        end
    end

    // Frame sequencer: byte index, one-deep pending request and completed-frame count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            byte_idx    <= '0;
            pending     <= 1'b0;
            frames_sent <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pending <= 1'b0;
                    if (send_event) begin
                        state    <= ST_SEND;
                        byte_idx <= '0;
                    end
                end
                default: begin
                    if (handshake && last_byte) begin
                        frames_sent <= frames_sent + 8'd1;
                        byte_idx    <= '0;
                        pending     <= 1'b0;
                        if (!chain_frame) begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        if (handshake) begin
                            byte_idx <= byte_idx + 4'd1;
                        end
                        if (send_event) begin
                            pending <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Assemble the payload bytes and checksum from the snapshot.
    always_comb begin
        b1       = snap_pl1_posx[11:4];
        b2       = {snap_pl1_posx[3:0], snap_pl1_posy[11:8]};
        b3       = snap_pl1_posy[7:0];
        b4       = snap_ball_xpos[11:4];
        b5       = {snap_ball_xpos[3:0], snap_ball_ypos[11:8]};
        b6       = snap_ball_ypos[7:0];
        b7       = {snap_score_pl1, snap_score_pl2};
        b8       = {5'b00000, snap_endgame, snap_whistle, snap_last_touch};
        checksum = b1 ^ b2 ^ b3 ^ b4 ^ b5 ^ b6 ^ b7 ^ b8;
    end

    // Select the byte currently offered to the transmitter.
    always_comb begin
        frame_byte = 8'h00;
        case (byte_idx)
            4'd0:    frame_byte = HEADER;
            4'd1:    frame_byte = b1;
            4'd2:    frame_byte = b2;
            4'd3:    frame_byte = b3;
            4'd4:    frame_byte = b4;
            4'd5:    frame_byte = b5;
            4'd6:    frame_byte = b6;
            4'd7:    frame_byte = b7;
            4'd8:    frame_byte = b8;
            4'd9:    frame_byte = checksum;
            default: frame_byte = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler: basic frame, backpressure, whistle
// latch, overlapping ticks, asynchronous reset mid-frame and tick division.
module tb_uart_frame_scheduler;

    typedef struct packed {
        logic [11:0] p1x;
        logic [11:0] p1y;
        logic [11:0] bx;
        logic [11:0] by;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic        eg;
        logic        wh;
        logic        lt;
    } frame_t;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        frame_tick;
    logic [11:0] pl1_posx;
    logic [11:0] pl1_posy;
    logic [11:0] ball_xpos;
    logic [11:0] ball_ypos;
    logic [3:0]  score_pl1;
    logic [3:0]  score_pl2;
    logic        endgame;
    logic        whistle_play;
    logic        last_touch;
    logic        busy;
    logic [7:0]  frames_sent;
    logic        busy3;
    logic [7:0]  frames_sent3;

    uart_frame_scheduler_if tx_bus ();
    uart_frame_scheduler_if tx_bus3 ();

    int          n_checks;
    int          n_errors;
    logic [7:0]  rx_q[$];
    int          busy_cycles;
    int          stable_errs;
    logic        prev_valid;
    logic        prev_ready;
    logic [7:0]  prev_data;
    logic        bp_mode;
    int          bp_idx;
    logic [3:0]  bp_pattern;

    uart_frame_scheduler #(.HEADER(8'hA5), .TICK_DIV(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .frame_tick   (frame_tick),
        .pl1_posx     (pl1_posx),
        .pl1_posy     (pl1_posy),
        .ball_xpos    (ball_xpos),
        .ball_ypos    (ball_ypos),
        .score_pl1    (score_pl1),
        .score_pl2    (score_pl2),
        .endgame      (endgame),
        .whistle_play (whistle_play),
        .last_touch   (last_touch),
        .tx           (tx_bus),
        .busy         (busy),
        .frames_sent  (frames_sent)
    );

    uart_frame_scheduler #(.HEADER(8'hA5), .TICK_DIV(3)) dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .frame_tick   (frame_tick),
        .pl1_posx     (pl1_posx),
        .pl1_posy     (pl1_posy),
        .ball_xpos    (ball_xpos),
        .ball_ypos    (ball_ypos),
        .score_pl1    (score_pl1),
        .score_pl2    (score_pl2),
        .endgame      (endgame),
        .whistle_play (whistle_play),
        .last_touch   (last_touch),
        .tx           (tx_bus3),
        .busy         (busy3),
        .frames_sent  (frames_sent3)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Capture accepted bytes, count busy cycles and check hold-stability under backpressure.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_data  = 8'h00;
        end else begin
            if (prev_valid && !prev_ready &&
                (tx_bus.tx_valid !== 1'b1 || tx_bus.tx_data !== prev_data)) begin
                stable_errs++;
            end
            if (tx_bus.tx_valid && tx_bus.tx_ready) begin
                rx_q.push_back(tx_bus.tx_data);
            end
            if (busy) begin
                busy_cycles++;
            end
            prev_valid = tx_bus.tx_valid;
            prev_ready = tx_bus.tx_ready;
            prev_data  = tx_bus.tx_data;
        end
    end

    function automatic logic [7:0] frameByte(input frame_t f, input int idx);
        logic [7:0] b [0:9];
        b[0] = 8'hA5;
        b[1] = f.p1x[11:4];
        b[2] = {f.p1x[3:0], f.p1y[11:8]};
        b[3] = f.p1y[7:0];
        b[4] = f.bx[11:4];
        b[5] = {f.bx[3:0], f.by[11:8]};
        b[6] = f.by[7:0];
        b[7] = {f.s1, f.s2};
        b[8] = {5'b00000, f.eg, f.wh, f.lt};
        b[9] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6] ^ b[7] ^ b[8];
        return b[idx];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic setFields(input frame_t f);
        pl1_posx   = f.p1x;
        pl1_posy   = f.p1y;
        ball_xpos  = f.bx;
        ball_ypos  = f.by;
        score_pl1  = f.s1;
        score_pl2  = f.s2;
        endgame    = f.eg;
        last_touch = f.lt;
    endtask

    // One clock of stimulus; entered and left 1 ns after a rising edge.
    task automatic applyStimulus(input logic tick, input logic whistle);
        frame_tick   = tick;
        whistle_play = whistle;
        if (bp_mode) begin
            tx_bus.tx_ready = bp_pattern[bp_idx];
            bp_idx = (bp_idx + 1) % 4;
        end
        @(posedge clk);
        #1;
        frame_tick   = 1'b0;
        whistle_play = 1'b0;
    endtask

    task automatic waitFrames(input logic [7:0] target, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (frames_sent == target) break;
            applyStimulus(1'b0, 1'b0);
        end
        checkOutput("wait_frames_sent", {24'd0, frames_sent}, {24'd0, target});
    endtask

    task automatic checkFrame(input string tag, input frame_t f, input int base);
        for (int i = 0; i < 10; i++) begin
            if (base + i < rx_q.size()) begin
                checkOutput($sformatf("%s[%0d]", tag, i), {24'd0, rx_q[base + i]},
                            {24'd0, frameByte(f, i)});
            end else begin
                checkOutput($sformatf("%s[%0d]_missing", tag, i), rx_q.size(), base + i + 1);
            end
        end
    endtask

    task automatic tickAndSettle();
        applyStimulus(1'b1, 1'b0);
        repeat (14) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    frame_t f_basic;
    frame_t f_bp;
    frame_t f_tmp;

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        busy_cycles     = 0;
        stable_errs     = 0;
        bp_mode         = 1'b0;
        bp_idx          = 0;
        bp_pattern      = 4'b1001;
        rst_n           = 1'b1;
        enable          = 1'b1;
        frame_tick      = 1'b0;
        whistle_play    = 1'b0;
        tx_bus.tx_ready  = 1'b1;
        tx_bus3.tx_ready = 1'b1;

        f_basic = '{p1x: 12'h123, p1y: 12'h456, bx: 12'h789, by: 12'hABC,
                    s1: 4'd3, s2: 4'd5, eg: 1'b0, wh: 1'b0, lt: 1'b1};
        f_bp    = '{p1x: 12'hFED, p1y: 12'h0A1, bx: 12'h3C5, by: 12'h7E2,
                    s1: 4'd9, s2: 4'd2, eg: 1'b1, wh: 1'b0, lt: 1'b0};
        setFields(f_basic);

        // Reset state
        #1 rst_n = 1'b0;
        #11;
        checkOutput("reset_tx_valid", {31'd0, tx_bus.tx_valid}, 32'd0);
        checkOutput("reset_tx_data", {24'd0, tx_bus.tx_data}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_frames_sent", {24'd0, frames_sent}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame with ready always high
        rx_q.delete();
        busy_cycles = 0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("latency_tx_valid", {31'd0, tx_bus.tx_valid}, 32'd1);
        checkOutput("first_byte_header", {24'd0, tx_bus.tx_data}, 32'h0000_00A5);
        waitFrames(8'd1, 40);
        repeat (3) applyStimulus(1'b0, 1'b0);
        checkFrame("basic", f_basic, 0);
        // 12^34^56^78^9A^BC^35^01 worked by hand
        checkOutput("basic_checksum_hand", (rx_q.size() > 9) ? {24'd0, rx_q[9]} : 32'hDEAD,
                    32'h0000_001A);
        checkOutput("basic_busy_cycles", busy_cycles, 32'd10);
        checkOutput("basic_tx_valid_dropped", {31'd0, tx_bus.tx_valid}, 32'd0);

        // Backpressure: ready pattern 1,0,0,1 repeating
        rx_q.delete();
        busy_cycles = 0;
        stable_errs = 0;
        setFields(f_bp);
        bp_mode = 1'b1;
        bp_idx  = 0;
        applyStimulus(1'b1, 1'b0);
        waitFrames(8'd2, 100);
        bp_mode = 1'b0;
        tx_bus.tx_ready = 1'b1;
        repeat (2) applyStimulus(1'b0, 1'b0);
        checkFrame("bp", f_bp, 0);
        checkOutput("bp_hold_stable", stable_errs, 32'd0);
        checkOutput("bp_frame_stretched", {31'd0, (busy_cycles > 10)}, 32'd1);

        // Whistle pulse between ticks lands in the next frame only
        rx_q.delete();
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        waitFrames(8'd3, 40);
        f_tmp = f_bp;
        f_tmp.wh = 1'b1;
        checkFrame("whistle_set", f_tmp, 0);
        rx_q.delete();
        applyStimulus(1'b1, 1'b0);
        waitFrames(8'd4, 40);
        checkFrame("whistle_clear", f_bp, 0);
        // Whistle coincident with the snapshot shows up one frame later
        rx_q.delete();
        applyStimulus(1'b1, 1'b1);
        waitFrames(8'd5, 40);
        checkFrame("whistle_coinc_now", f_bp, 0);
        rx_q.delete();
        applyStimulus(1'b1, 1'b0);
        waitFrames(8'd6, 40);
        checkFrame("whistle_coinc_next", f_tmp, 0);

        // Overlap: extra ticks during a frame yield exactly one chained frame
        rx_q.delete();
        busy_cycles = 0;
        repeat (2) applyStimulus(1'b0, 1'b0);
        setFields(f_basic);
        applyStimulus(1'b1, 1'b0);
        pl1_posx = 12'h0F0;
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        waitFrames(8'd8, 80);
        repeat (12) applyStimulus(1'b0, 1'b0);
        checkOutput("overlap_frames_sent", {24'd0, frames_sent}, 32'd8);
        checkOutput("overlap_busy_cycles", busy_cycles, 32'd20);
        checkOutput("overlap_byte_count", rx_q.size(), 32'd20);
        checkFrame("overlap_first", f_basic, 0);
        f_tmp = f_basic;
        f_tmp.p1x = 12'h0F0;
        checkFrame("overlap_second", f_tmp, 10);

        // Asynchronous reset while byte 4 is on the bus
        setFields(f_basic);
        applyStimulus(1'b1, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0);
        checkOutput("pre_reset_byte4", {24'd0, tx_bus.tx_data}, 32'h0000_0078);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_tx_valid", {31'd0, tx_bus.tx_valid}, 32'd0);
        checkOutput("async_rst_tx_data", {24'd0, tx_bus.tx_data}, 32'd0);
        checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("async_rst_frames_sent", {24'd0, frames_sent}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("post_rst_idle", {31'd0, tx_bus.tx_valid}, 32'd0);
        rx_q.delete();
        applyStimulus(1'b1, 1'b0);
        waitFrames(8'd1, 40);
        repeat (2) applyStimulus(1'b0, 1'b0);
        checkOutput("post_rst_byte_count", rx_q.size(), 32'd10);
        checkFrame("post_rst", f_basic, 0);

        // Divider by 3 and ticks ignored while disabled
        applyReset();
        tickAndSettle();
        tickAndSettle();
        checkOutput("div3_after_2", {24'd0, frames_sent3}, 32'd0);
        tickAndSettle();
        checkOutput("div3_after_3", {24'd0, frames_sent3}, 32'd1);
        enable = 1'b0;
        tickAndSettle();
        tickAndSettle();
        checkOutput("disabled_div1", {24'd0, frames_sent}, 32'd3);
        checkOutput("disabled_div3", {24'd0, frames_sent3}, 32'd1);
        enable = 1'b1;
        tickAndSettle();
        tickAndSettle();
        checkOutput("div3_after_5", {24'd0, frames_sent3}, 32'd1);
        tickAndSettle();
        checkOutput("div3_after_6", {24'd0, frames_sent3}, 32'd2);
        checkOutput("div1_after_6", {24'd0, frames_sent}, 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
